// File: rtl/kara_add_sched.sv
// kara_add_sched: round-robin arbiter that time-shares one external 128-bit
// adder among NREQ requesters. Each 256-bit addition takes two adder passes:
// the low half, then the high half with the carry registered in between.
module kara_add_sched #(
  parameter int NREQ = 3,
  parameter int IDW  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*256-1:0]   req_a,
  input  logic [NREQ*256-1:0]   req_b,
  output logic [127:0]          add_a,
  output logic [127:0]          add_b,
  output logic                  add_cin,
  input  logic [127:0]          add_sum,
  input  logic                  add_cout,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [255:0]          rsp_sum,
  output logic                  rsp_cout,
  output logic                  busy
);

  localparam int HALF_W = 128;
  localparam int FULL_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    RESP = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_n;
  logic [FULL_W-1:0]   r_a;
  logic [FULL_W-1:0]   r_b;
  logic [IDW-1:0]      r_id;
  logic [IDW-1:0]      r_last;
  logic                r_carry;
  logic [FULL_W-1:0]   r_sum;
  logic                r_cout;
  logic [IDW-1:0]      w_gnt;
  logic                w_found;

  // Round-robin search: first valid requester after the last grant, wrapping.
  // Scanning from farthest to nearest lets the nearest hit win.
  always_comb begin
    w_gnt   = '0;
    w_found = 1'b0;
    for (int k = NREQ; k >= 1; k--) begin
      int idx;
      idx = (int'(r_last) + k) % NREQ;
      if (req_valid[idx]) begin
        w_gnt   = IDW'(idx);
        w_found = 1'b1;
      end
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_n;
  end

  // Next-state, accept strobe and shared-adder operand steering.
  always_comb begin
    w_state_n = r_state;
    req_ready = '0;
    add_a     = '0;
    add_b     = '0;
    add_cin   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_found) begin
          req_ready[w_gnt] = 1'b1;
          w_state_n        = LO;
        end
      end
      LO: begin
        add_a     = r_a[HALF_W-1:0];
        add_b     = r_b[HALF_W-1:0];
        w_state_n = HI;
      end
      HI: begin
        add_a     = r_a[FULL_W-1:HALF_W];
        add_b     = r_b[FULL_W-1:HALF_W];
        add_cin   = r_carry;
        w_state_n = RESP;
      end
      RESP: begin
        if (rsp_ready) w_state_n = IDLE;
      end
      default: w_state_n = IDLE;
    endcase
  end

  // Operand capture at accept, per-pass result capture, round-robin pointer.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_id    <= '0;
      r_last  <= IDW'(NREQ - 1);
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_found) begin
            r_a    <= req_a[int'(w_gnt)*FULL_W +: FULL_W];
            r_b    <= req_b[int'(w_gnt)*FULL_W +: FULL_W];
            r_id   <= w_gnt;
            r_last <= w_gnt;
          end
        end
        LO: begin
          r_sum[HALF_W-1:0] <= add_sum;
          r_carry           <= add_cout;
        end
        HI: begin
          r_sum[FULL_W-1:HALF_W] <= add_sum;
          r_cout                 <= add_cout;
        end
        default: ;
      endcase
    end
  end

  assign rsp_valid = (r_state == RESP);
  assign rsp_id    = r_id;
  assign rsp_sum   = r_sum;
  assign rsp_cout  = r_cout;
  assign busy      = (r_state != IDLE);

endmodule
